// File: rtl/lc2k_exec_unit.sv
// lc2k_exec_unit: LC2K execute stage with operand-B mux, ALU, BEQ flag and a registered result/timebase stage.
// Optional registered zero/overflow flags are enabled with LC2K_EXEC_FLAGS_EN.
module lc2k_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluValA,
  input  logic [31:0] regBvalue,
  input  logic [31:0] offsetExtended,
  input  logic        CONTROL_ALUvalB,
  input  logic [1:0]  CONTROL_OPERATION,
  input  logic        CONTROL_ALU_START,
  output logic [31:0] aluValB,
  output logic [31:0] aluResult,
  output logic        CONTROL_BEQ,
  output logic [31:0] aluResultQ,
  output logic        beqQ,
  output logic        CONTROL_ALU_DONE,
`ifdef LC2K_EXEC_FLAGS_EN
  output logic        aluZeroQ,
  output logic        aluOverflowQ,
`endif
  output logic [31:0] cycleCount
);
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] r_res;
  logic        r_beq;
  logic        r_done;
  logic [31:0] r_cnt;
  assign aluValB = CONTROL_ALUvalB ? offsetExtended : regBvalue;
  assign w_sum   = aluValA + aluValB;
  assign w_diff  = aluValA - aluValB;
  always_comb begin
    aluResult   = CONTROL_OPERATION == 2'b00 ? w_sum :
                  CONTROL_OPERATION == 2'b01 ? ~(aluValA | aluValB) :
                  CONTROL_OPERATION == 2'b10 ? w_diff : aluValA;
    CONTROL_BEQ = (CONTROL_OPERATION == 2'b10) && (aluValA == aluValB);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res  <= '0;
      r_beq  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= CONTROL_ALU_START;
      r_cnt  <= r_cnt + 32'd1;
      if (CONTROL_ALU_START) begin
        r_res <= aluResult;
        r_beq <= CONTROL_BEQ;
      end
    end
  end
  assign aluResultQ       = r_res;
  assign beqQ             = r_beq;
  assign CONTROL_ALU_DONE = r_done;
  assign cycleCount       = r_cnt;
`ifdef LC2K_EXEC_FLAGS_EN
  logic w_ovf;
  logic r_zero;
  logic r_ovf;
  // Add overflows when like-signed operands give an opposite-signed sum; subtract when unlike-signed.
  assign w_ovf = CONTROL_OPERATION == 2'b00 ? (aluValA[31] == aluValB[31]) && (w_sum[31] != aluValA[31]) :
                 CONTROL_OPERATION == 2'b10 ? (aluValA[31] != aluValB[31]) && (w_diff[31] != aluValA[31]) : 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (CONTROL_ALU_START) begin
      r_zero <= aluResult == 32'd0;
      r_ovf  <= w_ovf;
    end
  end
  assign aluZeroQ     = r_zero;
  assign aluOverflowQ = r_ovf;
`endif
endmodule

// File: tb/tb_lc2k_exec_unit.sv
// tb_lc2k_exec_unit: directed self-checking bench for lc2k_exec_unit.
module tb_lc2k_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, off;
  logic        sel;
  logic [1:0]  op;
  logic        start;
  logic [31:0] valb, res, resq, cnt;
  logic        beq, beqq, done;
`ifdef LC2K_EXEC_FLAGS_EN
  logic        zq, ovq;
`endif
  int checks = 0;
  int errors = 0;
  lc2k_exec_unit dut (
    .clk(clk), .rst(rst), .aluValA(a), .regBvalue(b), .offsetExtended(off),
    .CONTROL_ALUvalB(sel), .CONTROL_OPERATION(op), .CONTROL_ALU_START(start),
    .aluValB(valb), .aluResult(res), .CONTROL_BEQ(beq), .aluResultQ(resq),
    .beqQ(beqq), .CONTROL_ALU_DONE(done),
`ifdef LC2K_EXEC_FLAGS_EN
    .aluZeroQ(zq), .aluOverflowQ(ovq),
`endif
    .cycleCount(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vo,
                       input logic vs, input logic [1:0] vop, input logic vst);
    a = va; b = vb; off = vo; sel = vs; op = vop; start = vst;
    #1;
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 5, 32'hFFFFFFFF, 0, 2'b00, 0);
    chk("mux_regb", valb, 32'd5);
    sel = 1'b1; #1;
    chk("mux_off", valb, 32'hFFFFFFFF);
    drive(7, 0, 32'hFFFFFFFF, 1, 2'b00, 0);
    chk("add_wrap", res, 32'd6);
    drive(32'h0F0F0F0F, 0, 0, 0, 2'b01, 0);
    chk("nor", res, 32'hF0F0F0F0);
    drive(32'h1234, 99, 0, 0, 2'b11, 0);
    chk("passa", res, 32'h1234);
    chk("passa_beq", beq, 0);
    drive(9, 9, 0, 0, 2'b10, 0);
    chk("eq_same_beq", beq, 1);
    chk("eq_same_res", res, 0);
    drive(9, 4, 0, 0, 2'b10, 0);
    chk("eq_diff_beq", beq, 0);
    chk("eq_diff_res", res, 5);
    drive(9, 9, 0, 0, 2'b00, 0);
    chk("add_beq", beq, 0);
    chk("add_res", res, 18);
    edge1();
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_resq", resq, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(2, 3, 0, 0, 2'b00, 1);
    edge1();
    chk("start_resq", resq, 5);
    chk("start_done", done, 1);
    chk("cnt1", cnt, 1);
    drive(9, 9, 0, 0, 2'b00, 0);
    edge1();
    chk("done_drop", done, 0);
    chk("hold_resq", resq, 5);
    chk("cnt2", cnt, 2);
    edge1();
    chk("cnt3", cnt, 3);
    chk("hold_resq2", resq, 5);
    drive(1, 1, 0, 0, 2'b00, 1);
    edge1();
    chk("b2b_res1", resq, 2);
    chk("b2b_done1", done, 1);
    drive(0, 0, 0, 0, 2'b01, 1);
    edge1();
    chk("b2b_res2", resq, 32'hFFFFFFFF);
    chk("b2b_done2", done, 1);
    drive(9, 9, 0, 0, 2'b10, 1);
    edge1();
    chk("beqq", beqq, 1);
    chk("eq_resq", resq, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_resq", resq, 0);
    chk("async_beqq", beqq, 0);
    chk("async_done", done, 0);
    chk("async_cnt", cnt, 0);
    chk("comb_in_rst", beq, 1);
    edge1();
    chk("rst_start_done", done, 0);
    chk("rst_start_resq", resq, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(4, 4, 0, 0, 2'b00, 1);
    edge1();
    chk("post_rst_cnt", cnt, 1);
    chk("post_rst_done", done, 1);
    chk("post_rst_resq", resq, 8);
`ifdef LC2K_EXEC_FLAGS_EN
    drive(32'h7FFFFFFF, 1, 0, 0, 2'b00, 1);
    edge1();
    chk("ovf_add", ovq, 1);
    chk("zero_add", zq, 0);
    drive(3, 3, 0, 0, 2'b10, 1);
    edge1();
    chk("zero_eq", zq, 1);
    chk("ovf_eq", ovq, 0);
    drive(32'h80000000, 1, 0, 0, 2'b10, 1);
    edge1();
    chk("ovf_sub", ovq, 1);
    drive(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 2'b11, 0);
    edge1();
    chk("flag_hold", ovq, 1);
`endif
    start = 1'b0;
    @(negedge clk);
    force dut.r_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_cnt;
    #1;
    chk("cnt_forced", cnt, 32'hFFFFFFFF);
    edge1();
    chk("cnt_wrap", cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
